// File: rtl/enc_pkg.sv
// Shared types and helpers for the quadrature encoder interface.
package enc_pkg;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Filtered encoder state packed as {A,B}.
  typedef logic [1:0] quad_state_t;

  typedef struct packed {
    logic inc;
    logic dec;
    logic illegal;
  } quad_dec_t;

  // Position of a state along the forward cycle 00->10->11->01.
  function automatic logic [1:0] quad_phase(input quad_state_t s);
    return {s[0], s[1] ^ s[0]};
  endfunction

  // Classify a prev->next transition by its phase distance modulo 4.
  function automatic quad_dec_t quad_decode(input quad_state_t prev,
                                            input quad_state_t next);
    logic [1:0] delta;
    quad_dec_t  r;
    delta     = quad_phase(next) - quad_phase(prev);
    r.inc     = (delta == 2'd1);
    r.dec     = (delta == 2'd3);
    r.illegal = (delta == 2'd2);
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_channel.sv
// One encoder channel: synchroniser, glitch filter, x4 decoder, counter, error flag.
module quad_decoder_channel
  import enc_pkg::*;
#(
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clear,
  input  logic               err_clr,
  output logic [COUNT_W-1:0] count,
  output logic               step,
  output logic               dir,
  output logic               err
);

  localparam int             MIS_W    = $clog2(FILTER_LEN + 1);
  localparam logic [MIS_W-1:0] MIS_LAST = MIS_W'(FILTER_LEN - 1);

  quad_state_t      sync_q [SYNC_STAGES];
  quad_state_t      sync_out;
  quad_state_t      filt_q;
  quad_state_t      prev_q;
  logic [MIS_W-1:0] mis_q;
  logic             upd_q;
  logic             init_q;
  quad_dec_t        dec;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign dec      = quad_decode(prev_q, filt_q);

  // Metastability synchroniser for the raw {A,B} pair.
  // NOTE: the synchroniser stages are reset as well, so the filter compares
  // against a known 00 right after reset instead of X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {enc_a, enc_b};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Accept a new {A,B} only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= '0;
      prev_q <= '0;
      mis_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (sync_out == filt_q) begin
        mis_q <= '0;
      end else if (mis_q == MIS_LAST) begin
        // NOTE: non-blocking assignment means prev_q captures the old filt_q
        // here, which is exactly the "from" state the decoder needs.
        prev_q <= filt_q;
        filt_q <= sync_out;
        mis_q  <= '0;
        upd_q  <= 1'b1;
      end else begin
        mis_q <= mis_q + MIS_W'(1);
      end
    end
  end

  // Decode each filtered update into count/step/dir/err; first update only arms.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q <= 1'b1;
      count  <= '0;
      step   <= 1'b0;
      dir    <= DIR_REV;
      err    <= 1'b0;
    end else begin
      step <= 1'b0;
      if (err_clr) err <= 1'b0;
      if (upd_q) begin
        if (init_q) begin
          init_q <= 1'b0;
        end else if (dec.inc) begin
          count <= count + COUNT_W'(1);
          dir   <= DIR_FWD;
          step  <= 1'b1;
        end else if (dec.dec) begin
          count <= count - COUNT_W'(1);
          dir   <= DIR_REV;
          step  <= 1'b1;
        end else if (dec.illegal) begin
          err <= 1'b1;
        end
      end
      if (clear) count <= '0;
    end
  end

endmodule

// File: rtl/quad_encoder_array.sv
// N-channel quadrature encoder interface with a coherent snapshot register.
module quad_encoder_array
  import enc_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [CHANNELS-1:0]         ENC_A,
  input  logic [CHANNELS-1:0]         ENC_B,
  input  logic [CHANNELS-1:0]         clear,
  input  logic                        snapshot,
  input  logic                        err_clr,
  output logic [CHANNELS*COUNT_W-1:0] count_flat,
  output logic [CHANNELS*COUNT_W-1:0] snap_flat,
  output logic                        snap_valid,
  output logic [CHANNELS-1:0]         step,
  output logic [CHANNELS-1:0]         dir,
  output logic [CHANNELS-1:0]         err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    quad_decoder_channel #(
      .COUNT_W     (COUNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_ch (
      .clk     (CLK),
      .rst_n   (resetn),
      .enc_a   (ENC_A[i]),
      .enc_b   (ENC_B[i]),
      .clear   (clear[i]),
      .err_clr (err_clr),
      .count   (count_flat[i*COUNT_W +: COUNT_W]),
      .step    (step[i]),
      .dir     (dir[i]),
      .err     (err[i])
    );
  end

  // Latch every channel's pre-update count on the same edge; flag it next cycle.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      snap_flat  <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= snapshot;
      if (snapshot) snap_flat <= count_flat;
    end
  end

endmodule
